// File: rtl/aes_block_master.sv
// aes_block_master: Avalon-MM block mover between on-chip memory and a
// 128-bit cipher core. Reads four 32-bit words per block (lowest address
// is the most significant word), hands the block to the core over a
// valid/ready pair, takes the result back and writes it out as four words.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   cmd_start/src/dst/count       job request (ignored while busy)
//   busy, done                    job status, one-cycle completion pulse
//   avm_*                         Avalon-MM master, read latency 1
//   blk_out_*                     plaintext block to the cipher core
//   blk_in_*                      result block from the cipher core
//
// Build option: define AES_BLOCK_MASTER_BYTESWAP_EN to byte-reverse every
// 32-bit word on read capture and on write drive.
module aes_block_master #(
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_start,
   input  logic [ADDR_W-1:0] cmd_src,
   input  logic [ADDR_W-1:0] cmd_dst,
   input  logic [15:0]       cmd_count,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_chipselect,
   output logic              avm_write,
   output logic [3:0]        avm_byteenable,
   output logic [31:0]       avm_writedata,
   input  logic [31:0]       avm_readdata,
   output logic [127:0]      blk_out_data,
   output logic              blk_out_valid,
   input  logic              blk_out_ready,
   input  logic [127:0]      blk_in_data,
   input  logic              blk_in_valid,
   output logic              blk_in_ready
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD    = 3'd1,
      RLAST = 3'd2,
      OUT   = 3'd3,
      IN    = 3'd4,
      WR    = 3'd5,
      FIN   = 3'd6
   } state_t;

   function automatic logic [31:0] conv(input logic [31:0] w);
`ifdef AES_BLOCK_MASTER_BYTESWAP_EN
      conv = {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      conv = w;
`endif
   endfunction

   function automatic logic [31:0] word_sel(
      input logic [127:0] b,
      input logic [1:0]   i
   );
      case (i)
         2'd0:    word_sel = b[127:96];
         2'd1:    word_sel = b[95:64];
         2'd2:    word_sel = b[63:32];
         default: word_sel = b[31:0];
      endcase
   endfunction

   state_t              state_q, state_d;
   logic [1:0]          k_q, k_d;
   logic [15:0]         blk_q, blk_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [127:0]        buf_q, buf_d;
   logic [127:0]        res_q, res_d;

   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                cs_q, cs_d;
   logic                we_q, we_d;
   logic [3:0]          be_q, be_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                ovalid_q, ovalid_d;
   logic                iready_q, iready_d;

   // nra: address of the read issued in the next cycle, if any
   logic [ADDR_W-1:0]   nra;
   logic                cap;
   logic [1:0]          cap_idx;
   logic [31:0]         rword;
   logic                last_blk;

   assign last_blk = ({1'b0, blk_q} + 17'd1) >= {1'b0, cnt_q};
   assign rword    = conv(avm_readdata);

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      blk_d    = blk_q;
      cnt_d    = cnt_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      buf_d    = buf_q;
      res_d    = res_q;
      nra      = rd_ptr_q;
      cap      = 1'b0;
      cap_idx  = 2'd0;

      unique case (state_q)
         IDLE: begin
            if (cmd_start) begin
               cnt_d    = cmd_count;
               blk_d    = 16'd0;
               k_d      = 2'd0;
               nra      = cmd_src;
               rd_ptr_d = cmd_src;
               wr_ptr_d = cmd_dst;
               state_d  = (cmd_count == 16'd0) ? FIN : RD;
            end
         end
         RD: begin
            // readdata in this cycle belongs to the previous read
            cap     = (k_q != 2'd0);
            cap_idx = k_q - 2'd1;
            k_d     = k_q + 2'd1;
            if (k_q == 2'd3) begin
               state_d = RLAST;
            end
         end
         RLAST: begin
            cap     = 1'b1;
            cap_idx = 2'd3;
            state_d = OUT;
         end
         OUT: begin
            if (blk_out_ready) begin
               state_d = IN;
            end
         end
         IN: begin
            if (blk_in_valid) begin
               res_d   = blk_in_data;
               k_d     = 2'd0;
               state_d = WR;
            end
         end
         WR: begin
            k_d = k_q + 2'd1;
            if (k_q == 2'd3) begin
               if (last_blk) begin
                  state_d = FIN;
               end else begin
                  blk_d   = blk_q + 16'd1;
                  state_d = RD;
               end
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (cap) begin
         case (cap_idx)
            2'd0:    buf_d[127:96] = rword;
            2'd1:    buf_d[95:64]  = rword;
            2'd2:    buf_d[63:32]  = rword;
            default: buf_d[31:0]   = rword;
         endcase
      end

      // Outputs are registered, so they are decoded from the next state.
      addr_d   = '0;
      cs_d     = 1'b0;
      we_d     = 1'b0;
      be_d     = 4'h0;
      wdata_d  = 32'h0;

      if (state_d == RD) begin
         cs_d     = 1'b1;
         addr_d   = nra;
         rd_ptr_d = nra + ADDR_W'(1);
      end

      if (state_d == WR) begin
         cs_d     = 1'b1;
         we_d     = 1'b1;
         be_d     = 4'hF;
         addr_d   = wr_ptr_q;
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         wdata_d  = conv(word_sel(res_d, k_d));
      end

      busy_d   = (state_d != IDLE);
      done_d   = (state_q == FIN);
      ovalid_d = (state_d == OUT);
      iready_d = (state_d == IN);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         k_q      <= 2'd0;
         blk_q    <= 16'd0;
         cnt_q    <= 16'd0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         buf_q    <= '0;
         res_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         addr_q   <= '0;
         cs_q     <= 1'b0;
         we_q     <= 1'b0;
         be_q     <= 4'h0;
         wdata_q  <= 32'h0;
         ovalid_q <= 1'b0;
         iready_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         blk_q    <= blk_d;
         cnt_q    <= cnt_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         buf_q    <= buf_d;
         res_q    <= res_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         addr_q   <= addr_d;
         cs_q     <= cs_d;
         we_q     <= we_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         ovalid_q <= ovalid_d;
         iready_q <= iready_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign avm_address    = addr_q;
   assign avm_chipselect = cs_q;
   assign avm_write      = we_q;
   assign avm_byteenable = be_q;
   assign avm_writedata  = wdata_q;
   assign blk_out_data   = buf_q;
   assign blk_out_valid  = ovalid_q;
   assign blk_in_ready   = iready_q;

endmodule

// File: doc/aes_block_master.md
AES_BLOCK_MASTER -- requirements
Module: aes_block_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, meaning word-address width of the on-chip memory port.
REQ-002 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port cmd_start  input  1  one-cycle request to start a job.
REQ-005 SHALL have ports cmd_src, cmd_dst  input  ADDR_W each  word address of first source / destination word.
REQ-006 SHALL have port cmd_count  input  16  number of 128-bit blocks to process.
REQ-007 SHALL have ports busy  output  1  job in progress; done  output  1  one-cycle job-complete pulse.
REQ-008 SHALL have ports avm_address  output  ADDR_W, avm_chipselect  output  1, avm_write  output  1, avm_byteenable  output  4, avm_writedata  output  32, avm_readdata  input  32: Avalon-MM master, fixed read latency 1, no waitrequest.
REQ-009 SHALL have ports blk_out_data  output  128, blk_out_valid  output  1, blk_out_ready  input  1: plaintext block to cipher core.
REQ-010 SHALL have ports blk_in_data  input  128, blk_in_valid  input  1, blk_in_ready  output  1: result block from cipher core.

Function
REQ-011 SHALL implement states IDLE, RD, RLAST, OUT, IN, WR, FIN.
REQ-012 IDLE: on cmd_start SHALL latch cmd_src/cmd_dst/cmd_count, assert busy next cycle, go RD (count>0) or FIN (count=0, no bus cycle).
REQ-013 cmd_start while busy SHALL be ignored.
REQ-014 RD: 4 consecutive cycles, chipselect=1, write=0, address = src + 4*b + k, k=0..3, b = current block index.
REQ-015 readdata for word k SHALL be captured the cycle after its read; RLAST captures word 3 (block load = 5 cycles).
REQ-016 Word k SHALL map to block bits [127-32k -: 32] (lowest address = MSW).
REQ-017 OUT: blk_out_valid=1, blk_out_data stable until blk_out_valid&blk_out_ready, then IN.
REQ-018 IN: blk_in_ready=1; on blk_in_valid SHALL latch blk_in_data, go WR.
REQ-019 WR: 4 consecutive cycles, chipselect=1, write=1, byteenable=4'hF, address = dst + 4*b + k, writedata = result word k per REQ-016 mapping.
REQ-020 After WR: b+1 < count -> RD of next block; else FIN.
REQ-021 FIN: done=1 for exactly one cycle, busy=0 in that cycle, return IDLE.
REQ-022 Address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-023 Outside RD/RLAST-capture/WR, avm_chipselect and avm_write SHALL be 0; byteenable 4'h0 when not writing.
REQ-024 Throughput with always-ready core: 4+1+1+1+4 = 11 cycles per block minimum.

Reset
REQ-025 reset_n low SHALL immediately force state IDLE and all outputs 0 (busy, done, avm_*, blk_out_valid, blk_in_ready, data outputs).
REQ-026 Reset mid-job SHALL abandon the job with no further bus cycles and no done pulse.
REQ-027 Latched command registers and block counter SHALL reset to 0.

Configuration
REQ-028 Macro AES_BLOCK_MASTER_BYTESWAP_EN defined: each 32-bit word SHALL be byte-reversed on read capture and on write drive (little-endian Nios memory to big-endian AES bytes).
REQ-029 Macro undefined: words SHALL pass unmodified.

Verification
REQ-030 Single block: mem[0x10..0x13]=0x00112233,0x44556677,0x8899AABB,0xCCDDEEFF, src=0x10, dst=0x40, count=1, core echoes -> blk_out_data=0x00112233445566778899AABBCCDDEEFF, mem[0x40..0x43] identical, one done pulse.
REQ-031 count=0 -> done pulse 2 cycles after cmd_start, zero chipselect cycles.
REQ-032 count=3, core inverts data, blk_out_ready held low 5 cycles per block -> blk_out_data stable while stalled, dst+0..+11 hold inverted source.
REQ-033 ADDR_W=15, src=0x7FFE, count=1 -> reads 0x7FFE,0x7FFF,0x0000,0x0001.
REQ-034 reset_n low during second WR cycle of count=2 -> outputs 0 immediately, no done, remaining dst words unchanged.
REQ-035 With BYTESWAP_EN, mem word 0x00112233 -> block MSW 0x33221100; written back as 0x00112233 on echo.
